// File: rtl/conv_pkg.sv
// Shared types and helpers for the wide-to-narrow handshake converter family.
package conv_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } conv_state_e;

  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

  // Ceiling log2; callers guarantee v >= 2 so the result is at least 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_beat_sel.sv
// Combinational beat selector: picks slice idx_i of a wide word in the
// configured beat order. Shared with the narrow-to-wide gearbox.
module conv_beat_sel #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [IN_W-1:0]  sh_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [OUT_W-1:0] beat_o
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned NSLOT = 1 << IDX_W;

  logic [OUT_W-1:0] slot [NSLOT];

  // Slots beyond RATIO only exist to pad the index space to a power of two.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < RATIO) begin : g_used
      if (MSB_FIRST) begin : g_msb
        assign slot[g] = sh_i[IN_W - 1 - g * OUT_W -: OUT_W];
      end else begin : g_lsb
        assign slot[g] = sh_i[g * OUT_W +: OUT_W];
      end
    end else begin : g_pad
      assign slot[g] = '0;
    end
  end

  assign beat_o = slot[idx_i];

endmodule

// File: rtl/conv_wide_narrow_hs.sv
// Parallel-to-serial width converter with ready/valid on both sides and a
// one-word holding buffer. Optional macro CONV_IDLE_FILL_EN drives IDLE_SYM when idle.
module conv_wide_narrow_hs
  import conv_pkg::*;
#(
  parameter int unsigned      IN_W      = 32,
  parameter int unsigned      OUT_W     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [OUT_W-1:0] IDLE_SYM  = OUT_W'(IDLE_SYM_DEFAULT)
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             flush,
  input  logic [IN_W-1:0]  data_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             last_out
);

  localparam int unsigned      RATIO    = IN_W / OUT_W;
  localparam int unsigned      IDX_W    = clog2(RATIO);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  conv_state_e      state_q, state_d;
  logic [IN_W-1:0]  sh_q, sh_d;
  logic [IN_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] beat_c;
  logic             in_fire_c;
  logic             out_fire_c;
  logic             is_last_c;

  conv_beat_sel #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_beat_sel (
    .sh_i   (sh_q),
    .idx_i  (idx_q),
    .beat_o (beat_c)
  );

  assign is_last_c  = (idx_q == IDX_LAST);
  assign in_fire_c  = valid_in & ready_in;
  assign out_fire_c = valid_out & ready_out;

  // State register; flush shares the reset path for the FSM.
  always_ff @(posedge clk_4f) begin
    if (reset || flush) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage registers; flush keeps the stored words but rewinds the index.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      sh_q   <= '0;
      hold_q <= '0;
      idx_q  <= '0;
    end else if (flush) begin
      idx_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      hold_q <= hold_d;
      idx_q  <= idx_d;
    end
  end

  // Next-state and storage update.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          sh_d    = data_in;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_fire_c && is_last_c) begin
          idx_d = '0;
          if (in_fire_c) begin
            sh_d = data_in;
          end else begin
            state_d = EMPTY;
          end
        end else begin
          if (out_fire_c) begin
            idx_d = idx_q + IDX_ONE;
          end
          if (in_fire_c) begin
            hold_d  = data_in;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (out_fire_c && is_last_c) begin
          sh_d    = hold_q;
          idx_d   = '0;
          state_d = SHIFT;
        end else if (out_fire_c) begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

`ifdef CONV_IDLE_FILL_EN

  // Outputs decoded from registered state.
  always_comb begin
    valid_out = (state_q != EMPTY);
    last_out  = valid_out && is_last_c;
    ready_in  = (state_q != FULL) && !reset && !flush;
    data_out  = valid_out ? beat_c : IDLE_SYM;
  end

`else

  logic [OUT_W-1:0] dout_q, dout_d;
  logic [OUT_W-1:0] unused_idle_sym;

  assign unused_idle_sym = IDLE_SYM;

  // Last emitted beat, shown while no beat is valid.
  always_comb begin
    dout_d = dout_q;
    if (out_fire_c) begin
      dout_d = beat_c;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      dout_q <= '0;
    end else if (!flush) begin
      dout_q <= dout_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    valid_out = (state_q != EMPTY);
    last_out  = valid_out && is_last_c;
    ready_in  = (state_q != FULL) && !reset && !flush;
    data_out  = valid_out ? beat_c : dout_q;
  end

`endif

endmodule
